// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter
//   Shares the single data-memory port between two requesters: r0 (CPU
//   M-stage load/store path) and r1 (secondary master, e.g. debug or DMA).
//   Round-robin grant with one transaction in flight. Store data is
//   lane-shifted with matching byte enables. Misaligned or reserved ops get
//   an error response without touching memory. Loads return the raw 32-bit
//   word; lane extraction and sign extension happen downstream.
// Parameters
//   MEM_LAT        cycles from the issue cycle to m_rdata valid (>= 1)
// Ports
//   clk, reset     clock; synchronous active-high reset
//   rN_req_valid   request present (N = 0, 1); fields stable until accepted
//   rN_req_ready   request accepted this cycle (combinational, IDLE only)
//   rN_addr        byte address
//   rN_wdata       right-aligned store data
//   rN_op          00 word, 01 half, 10 byte, 11 reserved
//   rN_we          1 = store, 0 = load
//   rN_resp_valid  one-cycle completion pulse to the owner
//   rN_rdata       raw read word (0 for stores and errors), held between responses
//   rN_err         bad access flag, held between responses
//   m_addr         word-aligned memory address (ISSUE cycle only)
//   m_wdata        lane-shifted store data (ISSUE cycle only)
//   m_byteen       store byte enables (ISSUE cycle only)
//   m_re           load strobe (ISSUE cycle only)
//   m_rdata        memory read data, valid MEM_LAT cycles after issue
module dm_port_arbiter #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        r0_req_valid,
  output logic        r0_req_ready,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  input  logic [1:0]  r0_op,
  input  logic        r0_we,
  output logic        r0_resp_valid,
  output logic [31:0] r0_rdata,
  output logic        r0_err,
  input  logic        r1_req_valid,
  output logic        r1_req_ready,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  input  logic [1:0]  r1_op,
  input  logic        r1_we,
  output logic        r1_resp_valid,
  output logic [31:0] r1_rdata,
  output logic        r1_err,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_byteen,
  output logic        m_re,
  input  logic [31:0] m_rdata
);

  localparam int unsigned CW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state, state_n;
  logic          rr_ptr;      // last owner; the other side wins a tie
  logic          owner_q;
  logic          we_q;
  logic [CW-1:0] cnt;

  logic          sel, accept, bad;
  logic [31:0]   a_addr, a_wdata;
  logic [1:0]    a_op;
  logic          a_we;
  logic [31:0]   lane_wdata;
  logic [3:0]    lane_be;
  logic          resp_set, resp_owner, resp_err;
  logic [31:0]   resp_data;

  // Arbitration, request mux, alignment and lane placement
  always_comb begin
    sel          = r1_req_valid & (~r0_req_valid | ~rr_ptr);
    r0_req_ready = (state == IDLE) & r0_req_valid & ~sel;
    r1_req_ready = (state == IDLE) & r1_req_valid & sel;
    accept       = r0_req_ready | r1_req_ready;

    a_addr  = sel ? r1_addr  : r0_addr;
    a_wdata = sel ? r1_wdata : r0_wdata;
    a_op    = sel ? r1_op    : r0_op;
    a_we    = sel ? r1_we    : r0_we;

    case (a_op)
      2'b00:   bad = (a_addr[1:0] != 2'b00);
      2'b01:   bad = a_addr[0];
      2'b10:   bad = 1'b0;
      default: bad = 1'b1;
    endcase

    case (a_op)
      2'b00: begin
        lane_be    = 4'b1111;
        lane_wdata = a_wdata;
      end
      2'b01: begin
        lane_be    = a_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = a_addr[1] ? {a_wdata[15:0], 16'h0000} : {16'h0000, a_wdata[15:0]};
      end
      default: begin
        lane_be    = 4'b0001 << a_addr[1:0];
        lane_wdata = {24'h000000, a_wdata[7:0]} << {a_addr[1:0], 3'b000};
      end
    endcase
  end

  // Next state; resp_* describe the per-port result registered on entry to RESP
  always_comb begin
    state_n    = state;
    resp_set   = 1'b0;
    resp_owner = owner_q;
    resp_err   = 1'b0;
    resp_data  = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (bad) begin
            state_n    = RESP;
            resp_set   = 1'b1;
            resp_owner = sel;
            resp_err   = 1'b1;
          end else begin
            state_n = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_n  = RESP;
          resp_set = 1'b1;
        end else begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (cnt == CW'(1)) begin
          state_n   = RESP;
          resp_set  = 1'b1;
          resp_data = m_rdata;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    r0_resp_valid = (state == RESP) & ~owner_q;
    r1_resp_valid = (state == RESP) & owner_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= 1'b1;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      cnt      <= '0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_byteen <= '0;
      m_re     <= 1'b0;
      r0_rdata <= '0;
      r0_err   <= 1'b0;
      r1_rdata <= '0;
      r1_err   <= 1'b0;
    end else begin
      state    <= state_n;
      // Memory strobes are loaded on accept so they are live only in ISSUE
      m_addr   <= '0;
      m_wdata  <= '0;
      m_byteen <= '0;
      m_re     <= 1'b0;
      if (accept) begin
        owner_q <= sel;
        rr_ptr  <= sel;
        we_q    <= a_we;
        if (!bad) begin
          m_addr <= {a_addr[31:2], 2'b00};
          if (a_we) begin
            m_wdata  <= lane_wdata;
            m_byteen <= lane_be;
          end else begin
            m_re <= 1'b1;
          end
        end
      end
      if (state == ISSUE && !we_q) cnt <= CW'(MEM_LAT);
      if (state == WAIT)           cnt <= cnt - CW'(1);
      if (resp_set) begin
        if (resp_owner) begin
          r1_rdata <= resp_data;
          r1_err   <= resp_err;
        end else begin
          r0_rdata <= resp_data;
          r0_err   <= resp_err;
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_port_arbiter.sv
// tb_dm_port_arbiter
//   Directed bench for dm_port_arbiter with MEM_LAT = 2. Inputs change and
//   outputs are sampled in the low phase of the clock. The memory model
//   returns 0xDEADBEEF exactly MEM_LAT cycles after an m_re pulse and a
//   filler pattern otherwise.
module tb_dm_port_arbiter;

  localparam int unsigned LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_req_valid, r0_req_ready, r0_we, r0_resp_valid, r0_err;
  logic [31:0] r0_addr, r0_wdata, r0_rdata;
  logic [1:0]  r0_op;
  logic        r1_req_valid, r1_req_ready, r1_we, r1_resp_valid, r1_err;
  logic [31:0] r1_addr, r1_wdata, r1_rdata;
  logic [1:0]  r1_op;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_byteen;
  logic        m_re;

  logic [LAT-1:0] mem_pipe = '0;

  int n_checks = 0;
  int n_errors = 0;

  dm_port_arbiter #(.MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .r0_req_valid(r0_req_valid), .r0_req_ready(r0_req_ready), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_op(r0_op), .r0_we(r0_we), .r0_resp_valid(r0_resp_valid),
    .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req_valid(r1_req_valid), .r1_req_ready(r1_req_ready), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_op(r1_op), .r1_we(r1_we), .r1_resp_valid(r1_resp_valid),
    .r1_rdata(r1_rdata), .r1_err(r1_err),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_byteen(m_byteen), .m_re(m_re),
    .m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_pipe <= {mem_pipe[LAT-2:0], m_re};
  assign m_rdata = mem_pipe[LAT-1] ? 32'hDEADBEEF : 32'h5A5A5A5A;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic req0(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] op, input logic we);
    r0_req_valid = v; r0_addr = a; r0_wdata = d; r0_op = op; r0_we = we;
  endtask

  task automatic req1(input logic v, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] op, input logic we);
    r1_req_valid = v; r1_addr = a; r1_wdata = d; r1_op = op; r1_we = we;
  endtask

  task automatic idle_inputs();
    req0(1'b0, '0, '0, 2'b00, 1'b0);
    req1(1'b0, '0, '0, 2'b00, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    next_cyc();
    next_cyc();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    do_reset();

    // Reset values
    check("rst_m_addr",   m_addr,        32'h0);
    check("rst_m_byteen", m_byteen,      4'h0);
    check("rst_m_re",     m_re,          1'b0);
    check("rst_resp0",    r0_resp_valid, 1'b0);
    check("rst_resp1",    r1_resp_valid, 1'b0);
    check("rst_rdata0",   r0_rdata,      32'h0);
    check("rst_err1",     r1_err,        1'b0);

    // 1: r0 store word 0x12345678 to 0x100
    req0(1'b1, 32'h100, 32'h12345678, 2'b00, 1'b1);
    #1;
    check("t1_ready0", r0_req_ready, 1'b1);
    check("t1_ready1", r1_req_ready, 1'b0);
    next_cyc();
    idle_inputs();
    #1;
    check("t1_m_addr",   m_addr,        32'h100);
    check("t1_m_byteen", m_byteen,      4'hF);
    check("t1_m_wdata",  m_wdata,       32'h12345678);
    check("t1_m_re",     m_re,          1'b0);
    check("t1_resp_t1",  r0_resp_valid, 1'b0);
    next_cyc();
    check("t1_resp_t2",  r0_resp_valid, 1'b1);
    check("t1_err",      r0_err,        1'b0);
    check("t1_rdata",    r0_rdata,      32'h0);
    check("t1_byteen_t2", m_byteen,     4'h0);
    next_cyc();
    check("t1_resp_t3",  r0_resp_valid, 1'b0);

    // 2: r1 store byte 0xAB to 0x203
    req1(1'b1, 32'h203, 32'h000000AB, 2'b10, 1'b1);
    #1;
    check("t2_ready1", r1_req_ready, 1'b1);
    check("t2_ready0", r0_req_ready, 1'b0);
    next_cyc();
    idle_inputs();
    #1;
    check("t2_m_addr",   m_addr,   32'h200);
    check("t2_m_byteen", m_byteen, 4'b1000);
    check("t2_m_wdata",  m_wdata,  32'hAB000000);
    next_cyc();
    check("t2_resp1", r1_resp_valid, 1'b1);
    check("t2_err1",  r1_err,        1'b0);
    check("t2_resp0", r0_resp_valid, 1'b0);
    next_cyc();

    // 3: continuous contention after reset, stores complete in 3 cycles
    do_reset();
    req0(1'b1, 32'h0, 32'h11111111, 2'b00, 1'b1);
    req1(1'b1, 32'h4, 32'h22222222, 2'b00, 1'b1);
    for (int c = 0; c < 12; c++) begin
      #1;
      check($sformatf("t3_rdy0_c%0d", c),  r0_req_ready,  (c % 6) == 0);
      check($sformatf("t3_rdy1_c%0d", c),  r1_req_ready,  (c % 6) == 3);
      check($sformatf("t3_resp0_c%0d", c), r0_resp_valid, (c % 6) == 2);
      check($sformatf("t3_resp1_c%0d", c), r1_resp_valid, (c % 6) == 5);
      next_cyc();
    end
    idle_inputs();

    // 4: r0 load 0x104, MEM_LAT=2 -> response at T+4
    req0(1'b1, 32'h104, 32'h0, 2'b00, 1'b0);
    #1;
    check("t4_ready0", r0_req_ready, 1'b1);
    next_cyc();
    idle_inputs();
    #1;
    check("t4_m_re_t1",   m_re,     1'b1);
    check("t4_m_addr",    m_addr,   32'h104);
    check("t4_m_byteen",  m_byteen, 4'h0);
    check("t4_m_wdata",   m_wdata,  32'h0);
    next_cyc();
    check("t4_m_re_t2",   m_re,          1'b0);
    check("t4_resp_t2",   r0_resp_valid, 1'b0);
    next_cyc();
    check("t4_resp_t3",   r0_resp_valid, 1'b0);
    next_cyc();
    check("t4_resp_t4",   r0_resp_valid, 1'b1);
    check("t4_rdata",     r0_rdata,      32'hDEADBEEF);
    check("t4_err",       r0_err,        1'b0);
    next_cyc();
    check("t4_resp_t5",   r0_resp_valid, 1'b0);
    check("t4_rdata_hold", r0_rdata,     32'hDEADBEEF);

    // 5: misaligned half store, then reserved op
    req0(1'b1, 32'h101, 32'h0000BEEF, 2'b01, 1'b1);
    #1;
    check("t5a_ready0", r0_req_ready, 1'b1);
    next_cyc();
    idle_inputs();
    #1;
    check("t5a_resp",   r0_resp_valid, 1'b1);
    check("t5a_err",    r0_err,        1'b1);
    check("t5a_rdata",  r0_rdata,      32'h0);
    check("t5a_byteen", m_byteen,      4'h0);
    check("t5a_m_re",   m_re,          1'b0);
    next_cyc();
    req0(1'b1, 32'h0, 32'h0, 2'b11, 1'b0);
    #1;
    check("t5b_ready0", r0_req_ready, 1'b1);
    check("t5b_byteen_t0", m_byteen,  4'h0);
    next_cyc();
    idle_inputs();
    #1;
    check("t5b_resp",   r0_resp_valid, 1'b1);
    check("t5b_err",    r0_err,        1'b1);
    check("t5b_m_re",   m_re,          1'b0);
    check("t5b_byteen", m_byteen,      4'h0);
    next_cyc();
    check("t5b_resp_after", r0_resp_valid, 1'b0);
    check("t5b_err_hold",   r0_err,        1'b1);
    check("t5b_m_re_after", m_re,          1'b0);

    // 6: reset during WAIT of a load, then r1 load completes normally
    req0(1'b1, 32'h8, 32'h0, 2'b00, 1'b0);
    #1;
    check("t6_ready0", r0_req_ready, 1'b1);
    next_cyc();
    idle_inputs();
    #1;
    check("t6_m_re_issue", m_re, 1'b1);
    next_cyc();
    reset = 1'b1;
    next_cyc();
    reset = 1'b0;
    #1;
    check("t6_resp0_rst",  r0_resp_valid, 1'b0);
    check("t6_m_re_rst",   m_re,          1'b0);
    check("t6_m_addr_rst", m_addr,        32'h0);
    check("t6_ready0_rst", r0_req_ready,  1'b0);
    check("t6_ready1_rst", r1_req_ready,  1'b0);
    check("t6_err0_rst",   r0_err,        1'b0);
    next_cyc();
    check("t6_resp0_late", r0_resp_valid, 1'b0);
    req1(1'b1, 32'h204, 32'h0, 2'b00, 1'b0);
    #1;
    check("t6_ready1", r1_req_ready, 1'b1);
    next_cyc();
    idle_inputs();
    #1;
    check("t6_m_re1",   m_re,   1'b1);
    check("t6_m_addr1", m_addr, 32'h204);
    next_cyc();
    next_cyc();
    next_cyc();
    check("t6_resp1",   r1_resp_valid, 1'b1);
    check("t6_rdata1",  r1_rdata,      32'hDEADBEEF);
    check("t6_err1",    r1_err,        1'b0);
    check("t6_resp0",   r0_resp_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
